// File: rtl/seven_tube_decode.sv
// Recovers a 6-digit frame (nibbles + dots) by watching a multiplexed 7-segment bus.
// States: SYNC = waiting for a stable digit 0 | CAPTURE = collecting digits 1..5 in order.
module seven_tube_decode #(
  parameter int unsigned STABLE_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  seg,
  input  logic [2:0]  sel,
  output logic [23:0] data_out,
  output logic [5:0]  point_out,
  output logic        frame_valid,
  output logic        err
);

  typedef enum logic {ST_SYNC, ST_CAPTURE} state_t;

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC);
  localparam logic [7:0] CNT_PRE = 8'(STABLE_CYC - 1);

  logic [7:0]  r_seg_m, r_seg_s;
  logic [2:0]  r_sel_m, r_sel_s;
  logic [10:0] r_prev;
  logic [7:0]  r_cnt;
  logic [23:0] r_shadow_d;
  logic [5:0]  r_shadow_p;
  logic [2:0]  r_exp;
  logic        r_frame_valid, r_err;
  logic [23:0] r_data_out;
  logic [5:0]  r_point_out;
  state_t      r_state, w_state_nxt;

  logic [10:0] w_cur;
  logic        w_same, w_strobe;
  logic        w_valid, w_dot;
  logic [3:0]  w_nib;
  logic [23:0] w_ins_d;
  logic [5:0]  w_ins_p;
  logic        w_restart, w_store, w_publish, w_err_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_m <= '0;
      r_seg_s <= '0;
      r_sel_m <= '0;
      r_sel_s <= '0;
    end else begin
      r_seg_m <= seg;
      r_seg_s <= r_seg_m;
      r_sel_m <= sel;
      r_sel_s <= r_sel_m;
    end
  end

  assign w_cur  = {r_sel_s, r_seg_s};
  assign w_same = (w_cur == r_prev);
  // Strobe only on the transition into CNT_MAX, so each stable period yields one sample.
  assign w_strobe = w_same && (r_cnt == CNT_PRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
      r_cnt  <= '0;
    end else begin
      r_prev <= w_cur;
      if (!w_same)
        r_cnt <= '0;
      else if (r_cnt != CNT_MAX)
        r_cnt <= r_cnt + 8'd1;
    end
  end

  always_comb begin
    w_valid = 1'b1;
    w_nib   = 4'h0;
    case (r_seg_s[6:0])
      7'b1000000: w_nib = 4'h0;
      7'b1111001: w_nib = 4'h1;
      7'b0100100: w_nib = 4'h2;
      7'b0110000: w_nib = 4'h3;
      7'b0011001: w_nib = 4'h4;
      7'b0010010: w_nib = 4'h5;
      7'b0000010: w_nib = 4'h6;
      7'b1111000: w_nib = 4'h7;
      7'b0000000: w_nib = 4'h8;
      7'b0010000: w_nib = 4'h9;
      7'b0111111: w_nib = 4'hA;
      7'b1111111: w_nib = 4'hF;
      default:    w_valid = 1'b0;
    endcase
    // Minus and blank carry no decimal point.
    w_dot = ~r_seg_s[7] && (w_nib != 4'hA) && (w_nib != 4'hF);
  end

  always_comb begin
    w_ins_d = r_shadow_d;
    w_ins_p = r_shadow_p;
    for (int i = 0; i < 6; i++) begin
      if (r_sel_s == 3'(i)) begin
        w_ins_d[23-4*i -: 4] = w_nib;
        w_ins_p[5-i]         = w_dot;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_SYNC;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_store     = 1'b0;
    w_publish   = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_SYNC: begin
        if (w_strobe && (r_sel_s == 3'd0) && w_valid) begin
          w_restart   = 1'b1;
          w_state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (w_strobe) begin
          if ((r_sel_s == r_exp) && w_valid) begin
            if (r_sel_s == 3'd5) begin
              w_publish   = 1'b1;
              w_state_nxt = ST_SYNC;
            end else begin
              w_store = 1'b1;
            end
          end else begin
            w_err_set = 1'b1;
            // A fresh digit 0 on the failing strobe starts the next frame directly.
            if ((r_sel_s == 3'd0) && w_valid)
              w_restart = 1'b1;
            else
              w_state_nxt = ST_SYNC;
          end
        end
      end
      default: w_state_nxt = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_d    <= '0;
      r_shadow_p    <= '0;
      r_exp         <= '0;
      r_data_out    <= '0;
      r_point_out   <= '0;
      r_frame_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_frame_valid <= w_publish;
      r_err         <= w_err_set;
      if (w_restart) begin
        r_shadow_d <= {w_nib, 20'h0};
        r_shadow_p <= {w_dot, 5'b0};
        r_exp      <= 3'd1;
      end else if (w_store) begin
        r_shadow_d <= w_ins_d;
        r_shadow_p <= w_ins_p;
        r_exp      <= r_exp + 3'd1;
      end else if (w_publish) begin
        r_data_out  <= w_ins_d;
        r_point_out <= w_ins_p;
        r_shadow_d  <= '0;
        r_shadow_p  <= '0;
        r_exp       <= '0;
      end else if (w_err_set) begin
        r_shadow_d <= '0;
        r_shadow_p <= '0;
        r_exp      <= '0;
      end
    end
  end

  assign data_out    = r_data_out;
  assign point_out   = r_point_out;
  assign frame_valid = r_frame_valid;
  assign err         = r_err;

endmodule

// File: tb/tb_seven_tube_decode.sv
// Scoreboard bench: stimulus queues expected frame/err events, a monitor pops them as the DUT pulses.
module tb_seven_tube_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  seg = 8'hFF;
  logic [2:0]  sel = 3'd7;
  logic [23:0] data_out;
  logic [5:0]  point_out;
  logic        frame_valid;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_err;
    logic [23:0] d;
    logic [5:0]  p;
  } exp_t;

  exp_t exp_q[$];

  seven_tube_decode #(.STABLE_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .sel(sel),
    .data_out(data_out), .point_out(point_out),
    .frame_valid(frame_valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'b1000000;
      4'h1: enc = 7'b1111001;
      4'h2: enc = 7'b0100100;
      4'h3: enc = 7'b0110000;
      4'h4: enc = 7'b0011001;
      4'h5: enc = 7'b0010010;
      4'h6: enc = 7'b0000010;
      4'h7: enc = 7'b1111000;
      4'h8: enc = 7'b0000000;
      4'h9: enc = 7'b0010000;
      4'hA: enc = 7'b0111111;
      default: enc = 7'b1111111;
    endcase
  endfunction

  task automatic hold(input logic [2:0] s, input logic [7:0] g, input int n);
    sel = s;
    seg = g;
    repeat (n) @(negedge clk);
  endtask

  task automatic digit(input int i, input logic [23:0] d, input logic [5:0] p, input int n);
    logic [3:0] nib;
    nib = d[23-4*i -: 4];
    hold(3'(i), {~p[5-i], enc(nib)}, n);
  endtask

  task automatic frame(input logic [23:0] d, input logic [5:0] p);
    for (int i = 0; i < 6; i++) digit(i, d, p, 100);
  endtask

  task automatic push(input bit e, input logic [23:0] d, input logic [5:0] p);
    exp_t x;
    x.is_err = e;
    x.d = d;
    x.p = p;
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (rst_n && (frame_valid || err)) begin
      check("fv_err_exclusive", {31'd0, frame_valid & err}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_event", {30'd0, frame_valid, err}, 32'd0);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check("event_kind", {31'd0, err}, {31'd0, x.is_err});
        check("data_out", {8'd0, data_out}, {8'd0, x.d});
        check("point_out", {26'd0, point_out}, {26'd0, x.p});
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_data", {8'd0, data_out}, 32'd0);
    check("rst_point", {26'd0, point_out}, 32'd0);
    check("rst_fv", {31'd0, frame_valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    hold(3'd7, 8'hFF, 40);
    check("idle_data", {8'd0, data_out}, 32'd0);

    // Encoder-style cyclic scan, two passes.
    push(1'b0, 24'h123456, 6'b000100);
    push(1'b0, 24'h123456, 6'b000100);
    frame(24'h123456, 6'b000100);
    frame(24'h123456, 6'b000100);

    // Minus and blank digits; second pass drives dot bits low on A/F.
    push(1'b0, 24'hAF2345, 6'b000000);
    hold(3'd0, 8'hBF, 100);
    hold(3'd1, 8'hFF, 100);
    for (int i = 2; i < 6; i++) digit(i, 24'hAF2345, 6'b000000, 100);
    push(1'b0, 24'hAF2345, 6'b000000);
    hold(3'd0, 8'h3F, 100);
    hold(3'd1, 8'h7F, 100);
    for (int i = 2; i < 6; i++) digit(i, 24'hAF2345, 6'b000000, 100);

    // Glitch of STABLE_CYC-2 cycles before digit 2 has been sampled.
    push(1'b0, 24'h098765, 6'b100001);
    digit(0, 24'h098765, 6'b100001, 100);
    digit(1, 24'h098765, 6'b100001, 100);
    digit(2, 24'h098765, 6'b100001, 5);
    hold(3'd2, 8'hAA, 14);
    for (int i = 2; i < 6; i++) digit(i, 24'h098765, 6'b100001, 100);

    // Out-of-order select 0,1,3, then a clean pass.
    push(1'b1, 24'h098765, 6'b100001);
    digit(0, 24'h111111, 6'b000000, 100);
    digit(1, 24'h111111, 6'b000000, 100);
    digit(3, 24'h111111, 6'b000000, 100);
    check("hold_after_seq_err", {8'd0, data_out}, {8'd0, 24'h098765});
    push(1'b0, 24'h135790, 6'b010010);
    frame(24'h135790, 6'b010010);

    // Undecodable pattern on digit 2: err only, rest of pass ignored.
    push(1'b1, 24'h135790, 6'b010010);
    digit(0, 24'h222222, 6'b000000, 100);
    digit(1, 24'h222222, 6'b000000, 100);
    hold(3'd2, 8'b1010_1010, 100);
    for (int i = 3; i < 6; i++) digit(i, 24'h222222, 6'b000000, 100);
    check("hold_after_bad_pat", {8'd0, data_out}, {8'd0, 24'h135790});

    // Reset during digit 3.
    for (int i = 0; i < 3; i++) digit(i, 24'h246802, 6'b000000, 100);
    digit(3, 24'h246802, 6'b000000, 50);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_data", {8'd0, data_out}, 32'd0);
    check("mid_rst_point", {26'd0, point_out}, 32'd0);
    check("mid_rst_fv", {31'd0, frame_valid}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    digit(3, 24'h246802, 6'b000000, 50);
    digit(4, 24'h246802, 6'b000000, 100);
    digit(5, 24'h246802, 6'b000000, 100);
    check("post_rst_data", {8'd0, data_out}, 32'd0);
    push(1'b0, 24'h314159, 6'b001000);
    frame(24'h314159, 6'b001000);

    hold(3'd7, 8'hFF, 200);
    check("queue_drained", exp_q.size(), 32'd0);
    check("final_data", {8'd0, data_out}, {8'd0, 24'h314159});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_tube_decode.md
SEVEN_TUBE_DECODE -- requirements
Module: seven_tube_decode

Interface
REQ-001 SHALL provide parameter: STABLE_CYC, 16, number of clk cycles that synchronized sel/seg must hold unchanged before sampling; legal range 2..255.
REQ-002 SHALL provide port: clk  input  1  system clock.
REQ-003 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: seg  input  8  observed segment bus, active-low; seg[7] is the dot, seg[6:0] are segments g..a.
REQ-005 SHALL provide port: sel  input  3  observed digit select; 0 = leftmost digit, 5 = rightmost digit.
REQ-006 SHALL provide port: data_out  output  24  reconstructed nibbles; digit 0 maps to [23:20] and digit 5 maps to [3:0].
REQ-007 SHALL provide port: point_out  output  6  reconstructed dots, 1 = lit; digit 0 maps to [5] and digit 5 maps to [0].
REQ-008 SHALL provide port: frame_valid  output  1  one-cycle pulse when data_out/point_out are updated.
REQ-009 SHALL provide port: err  output  1  one-cycle pulse on a sequence error or an undecodable pattern.

Function
REQ-010 SHALL pass seg and sel through a 2-flop synchronizer before any other use; all later references are to the synchronized values.
REQ-011 SHALL maintain a stability counter: cleared when {sel,seg} differs from its previous-cycle value, otherwise incremented and saturating at STABLE_CYC.
REQ-012 SHALL assert an internal sample strobe only in the cycle the counter transitions to STABLE_CYC, giving exactly one strobe per stable period.
REQ-013 SHALL decode seg[6:0] on each strobe as follows:
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9.
  - 0111111=4'hA (minus sign); 1111111=4'hF (blank).
  - Any other value is invalid.
REQ-014 SHALL capture the dot as ~seg[7] for codes 0..9, and force the dot to 0 for codes A and F.
REQ-015 SHALL implement a two-state FSM, SYNC and CAPTURE; the reset state is SYNC.
REQ-016 In SYNC, on a strobe with sel==0 and a valid pattern: store digit 0 into the shadow registers, set expected index to 1, and go to CAPTURE.
REQ-017 In SYNC, SHALL ignore any other strobe silently (no err).
REQ-018 In CAPTURE, on a strobe with sel==expected and a valid pattern: store into the shadow registers and increment expected.
REQ-019 In CAPTURE, on a strobe with sel!=expected, sel>5, or an invalid pattern: pulse err the next cycle, discard the shadow registers, and go to SYNC.
REQ-020 If the error strobe carries sel==0 with a valid pattern, SHALL immediately restart CAPTURE with that digit instead of entering SYNC.
REQ-021 On storing digit 5, in the next cycle SHALL:
  - load data_out/point_out from the shadow registers;
  - pulse frame_valid for one cycle;
  - return to SYNC.
REQ-022 SHALL hold data_out/point_out unchanged between frame_valid pulses, including across errors.
REQ-023 SHALL never assert frame_valid and err in the same cycle; digit 5 with an invalid pattern yields err only.
REQ-024 Latency: an input change held stable reaches the strobe exactly 2+STABLE_CYC cycles after the change first appears at the pins; frame_valid follows the digit-5 strobe by 1 cycle.

Reset
REQ-025 On rst_n low, SHALL asynchronously clear:
  - synchronizer flops, stability counter, shadow registers and expected index;
  - data_out=0, point_out=0, frame_valid=0, err=0;
  - FSM to SYNC.
REQ-026 After reset release, SHALL publish nothing until a complete in-order 0..5 sequence has been captured; reset mid-frame discards the partial frame.

Verification
REQ-027 Encoder-equivalent stimulus (sel 0..5 cyclic, 100 cycles per digit, encoding data 24'h123456, point 6'b000100) -> data_out=24'h123456, point_out=6'b000100, one frame_valid per cycle through 0..5, err never asserted.
REQ-028 Frame with digit 0 seg=8'hBF (minus) and digit 1 seg=8'hFF (blank), remaining digits 2,3,4,5 -> data_out=24'hAF2345, point_out[5:4]=2'b00.
REQ-029 Glitch on seg lasting STABLE_CYC-2 cycles mid-digit -> no extra strobe, no err, frame still published correctly.
REQ-030 Sel sequence 0,1,3 -> err pulse at the strobe for 3, no frame_valid, data_out keeps its previous value; the next full 0..5 pass publishes normally.
REQ-031 Digit 2 with seg=8'b1010_1010 -> err pulse, no frame_valid for that pass.
REQ-032 rst_n low during digit 3 -> all outputs 0 immediately; the first frame_valid occurs only after the next complete 0..5 pass.
